// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin RAM arbiter.
//   state_t : arbiter FSM encoding (IDLE, ISSUE, WAIT, DONE)
//   clog2   : index width helper, never returns less than 1
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width needed to hold values 0..v-1; a 1-entry range still gets one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Core-side and RAM-side bus bundle for mem_rr_arbiter.
//   req/we/addr/wdata : per-core request, packed core i at [i*W +: W]
//   ack/rdata         : one-hot completion pulse and shared read data
//   ram_*             : single-port RAM macro connection
// Modports: slave = arbiter view, master = core/RAM environment view.
interface mem_rr_arbiter_if #(
    parameter int unsigned NCORES = 2,
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8
);
    logic [NCORES-1:0]    req;
    logic [NCORES-1:0]    we;
    logic [NCORES*AW-1:0] addr;
    logic [NCORES*DW-1:0] wdata;
    logic [NCORES-1:0]    ack;
    logic [DW-1:0]        rdata;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_din;
    logic                 ram_wren;
    logic [DW-1:0]        ram_q;

    modport slave (
        input  req, we, addr, wdata, ram_q,
        output ack, rdata, ram_addr, ram_din, ram_wren
    );

    modport master (
        output req, we, addr, wdata, ram_q,
        input  ack, rdata, ram_addr, ram_din, ram_wren
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req   : per-core request vector
//   ptr   : highest-priority index for this pick
//   grant : first requesting index scanning ptr, ptr+1, ... modulo NCORES
//   valid : at least one request is set
module rr_pick #(
    parameter int unsigned NCORES = 2,
    parameter int unsigned IW     = 1
) (
    input  logic [NCORES-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [IW-1:0]     grant,
    output logic              valid
);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < NCORES; i++) begin
            idx = (32'(ptr) + i) % NCORES;
            if (!valid && req[IW'(idx)]) begin
                valid = 1'b1;
                grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NCORES cores.
// Each granted request becomes one RAM access; the block waits out the
// RAM read latency and returns a one-cycle ack with read data.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_rr_arbiter_if slave (core req/ack side and RAM side)
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NCORES = 2,
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_rr_arbiter_if.slave   bus
);

    localparam int unsigned IW = clog2(NCORES);
    localparam int unsigned CW = clog2(RD_LAT + 1);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic          win_we;
    logic [CW-1:0] cnt;
    logic [IW-1:0] grant;
    logic          any_req;

    logic [AW-1:0] addr_a  [NCORES];
    logic [DW-1:0] wdata_a [NCORES];

    // Unpack per-core address and write data for indexed selection.
    always_comb begin
        for (int unsigned i = 0; i < NCORES; i++) begin
            addr_a[i]  = bus.addr[i*AW +: AW];
            wdata_a[i] = bus.wdata[i*DW +: DW];
        end
    end

    rr_pick #(
        .NCORES (NCORES),
        .IW     (IW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (grant),
        .valid (any_req)
    );

    // Arbiter FSM; the RAM address/data registers double as the request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            win          <= '0;
            win_we       <= 1'b0;
            cnt          <= '0;
            bus.ack      <= '0;
            bus.rdata    <= '0;
            bus.ram_addr <= '0;
            bus.ram_din  <= '0;
            bus.ram_wren <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win          <= grant;
                        win_we       <= bus.we[grant];
                        bus.ram_addr <= addr_a[grant];
                        bus.ram_din  <= wdata_a[grant];
                        bus.ram_wren <= bus.we[grant];
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.ram_wren <= 1'b0;
                    if (win_we) begin
                        bus.ack <= NCORES'(1) << win;
                        state   <= DONE;
                    end else begin
                        cnt   <= CW'(RD_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // Last WAIT cycle is when ram_q carries the addressed word.
                    if (cnt == CW'(1)) begin
                        bus.rdata <= bus.ram_q;
                        bus.ack   <= NCORES'(1) << win;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    bus.ack <= '0;
                    ptr     <= (win == IW'(NCORES - 1)) ? '0 : win + IW'(1);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench: dut_a (2 cores, RD_LAT=1) and dut_b (4 cores, RD_LAT=3),
// each with its own RAM model.
module tb_mem_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic ld_a, ld_b;
    logic [7:0] ld_addr, ld_data;

    int tests = 0;
    int fails = 0;

    mem_rr_arbiter_if #(.NCORES(2), .AW(8), .DW(8)) if_a ();
    mem_rr_arbiter_if #(.NCORES(4), .AW(8), .DW(8)) if_b ();

    mem_rr_arbiter #(.NCORES(2), .AW(8), .DW(8), .RD_LAT(1)) dut_a (
        .clk (clk), .rst (rst_a), .bus (if_a.slave)
    );
    mem_rr_arbiter #(.NCORES(4), .AW(8), .DW(8), .RD_LAT(3)) dut_b (
        .clk (clk), .rst (rst_b), .bus (if_b.slave)
    );

    // RAM models: registered read, latency pipeline matches RD_LAT.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] qa;
    logic [7:0] qb0, qb1, qb2;

    always @(posedge clk) begin
        if (ld_a) mem_a[ld_addr] <= ld_data;
        else if (if_a.ram_wren) mem_a[if_a.ram_addr] <= if_a.ram_din;
        qa <= mem_a[if_a.ram_addr];
    end
    assign if_a.ram_q = qa;

    always @(posedge clk) begin
        if (ld_b) mem_b[ld_addr] <= ld_data;
        else if (if_b.ram_wren) mem_b[if_b.ram_addr] <= if_b.ram_din;
        qb0 <= mem_b[if_b.ram_addr];
        qb1 <= qb0;
        qb2 <= qb1;
    end
    assign if_b.ram_q = qb2;

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic poke(input bit sel_b, input logic [7:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_a    = !sel_b;
        ld_b    = sel_b;
        cyc(1);
        ld_a = 1'b0;
        ld_b = 1'b0;
    endtask

    // Counts edges until an ack appears; n = max+1 means none arrived.
    task automatic wait_ack_a(input int max, output int n, output logic [1:0] av,
                              output logic [7:0] rd, output logic [7:0] iss,
                              output int wcnt, output logic [7:0] waddr,
                              output logic [7:0] wdin);
        n = max + 1; av = '0; rd = '0; iss = '0; wcnt = 0; waddr = '0; wdin = '0;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) iss = if_a.ram_addr;
            if (if_a.ram_wren) begin
                wcnt++;
                waddr = if_a.ram_addr;
                wdin  = if_a.ram_din;
            end
            if (if_a.ack != 2'b00) begin
                n  = i;
                av = if_a.ack;
                rd = if_a.rdata;
                return;
            end
        end
    endtask

    task automatic wait_ack_b(input int max, output int n, output logic [3:0] av,
                              output logic [7:0] rd);
        n = max + 1; av = '0; rd = '0;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            #1;
            if (if_b.ack != 4'b0000) begin
                n  = i;
                av = if_b.ack;
                rd = if_b.rdata;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        cyc(2);
        tests++; if (if_a.ack !== 2'b00) begin fails++; $display("FAIL rst_a_ack: got %b exp 00", if_a.ack); end
        tests++; if (if_a.rdata !== 8'h00) begin fails++; $display("FAIL rst_a_rdata: got %h exp 00", if_a.rdata); end
        tests++; if (if_a.ram_addr !== 8'h00) begin fails++; $display("FAIL rst_a_ram_addr: got %h exp 00", if_a.ram_addr); end
        tests++; if (if_a.ram_din !== 8'h00) begin fails++; $display("FAIL rst_a_ram_din: got %h exp 00", if_a.ram_din); end
        tests++; if (if_a.ram_wren !== 1'b0) begin fails++; $display("FAIL rst_a_wren: got %b exp 0", if_a.ram_wren); end
        tests++; if (if_b.ack !== 4'b0000) begin fails++; $display("FAIL rst_b_ack: got %b exp 0000", if_b.ack); end
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_single_read();
        int n, wc; logic [1:0] av; logic [7:0] rd, iss, wa, wd;
        if_a.we = 2'b00; if_a.addr = {8'h00, 8'h10}; if_a.req = 2'b01;
        wait_ack_a(10, n, av, rd, iss, wc, wa, wd);
        if_a.req = 2'b00;
        cyc(1);
        tests++; if (iss !== 8'h10) begin fails++; $display("FAIL read_issue_addr: got %h exp 10", iss); end
        tests++; if (n !== 3) begin fails++; $display("FAIL read_latency: got %0d exp 3", n); end
        tests++; if (av !== 2'b01) begin fails++; $display("FAIL read_ack: got %b exp 01", av); end
        tests++; if (rd !== 8'hA5) begin fails++; $display("FAIL read_data: got %h exp a5", rd); end
        tests++; if (wc !== 0) begin fails++; $display("FAIL read_wren: got %0d exp 0", wc); end
    endtask

    task automatic test_single_write();
        int n, wc; logic [1:0] av; logic [7:0] rd, iss, wa, wd;
        if_a.we = 2'b10; if_a.addr = {8'h20, 8'h00}; if_a.wdata = {8'h3C, 8'h00}; if_a.req = 2'b10;
        wait_ack_a(10, n, av, rd, iss, wc, wa, wd);
        if_a.req = 2'b00;
        cyc(1);
        tests++; if (n !== 2) begin fails++; $display("FAIL write_latency: got %0d exp 2", n); end
        tests++; if (av !== 2'b10) begin fails++; $display("FAIL write_ack: got %b exp 10", av); end
        tests++; if (wc !== 1) begin fails++; $display("FAIL write_wren_cycles: got %0d exp 1", wc); end
        tests++; if (wa !== 8'h20) begin fails++; $display("FAIL write_addr: got %h exp 20", wa); end
        tests++; if (wd !== 8'h3C) begin fails++; $display("FAIL write_din: got %h exp 3c", wd); end
        // Read the written word back through core 0.
        if_a.we = 2'b00; if_a.addr = {8'h00, 8'h20}; if_a.req = 2'b01;
        wait_ack_a(10, n, av, rd, iss, wc, wa, wd);
        if_a.req = 2'b00;
        cyc(1);
        tests++; if (av !== 2'b01) begin fails++; $display("FAIL readback_ack: got %b exp 01", av); end
        tests++; if (rd !== 8'h3C) begin fails++; $display("FAIL readback_data: got %h exp 3c", rd); end
    endtask

    task automatic test_fairness();
        int n, wc; logic [1:0] av; logic [7:0] rd, iss, wa, wd;
        logic [1:0] exp_av;
        rst_a = 1'b1; cyc(1); rst_a = 1'b0;
        if_a.we = 2'b11; if_a.addr = {8'h31, 8'h30}; if_a.wdata = {8'h22, 8'h11}; if_a.req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_ack_a(10, n, av, rd, iss, wc, wa, wd);
            exp_av = (k % 2 == 0) ? 2'b01 : 2'b10;
            tests++; if (av !== exp_av) begin fails++; $display("FAIL fair_ack_%0d: got %b exp %b", k, av, exp_av); end
            tests++; if (n !== ((k == 0) ? 2 : 3)) begin fails++; $display("FAIL fair_gap_%0d: got %0d exp %0d", k, n, (k == 0) ? 2 : 3); end
        end
        if_a.req = 2'b00;
        cyc(1);
    endtask

    task automatic test_req_dropped();
        int n, wc; logic [1:0] av; logic [7:0] rd, iss, wa, wd;
        // Last fairness grant was core 1, so the pointer sits at 0.
        if_a.we = 2'b10; if_a.addr = {8'h50, 8'h10}; if_a.wdata = {8'h77, 8'h00}; if_a.req = 2'b01;
        cyc(2);
        if_a.req = 2'b10;
        wait_ack_a(10, n, av, rd, iss, wc, wa, wd);
        tests++; if (n !== 1) begin fails++; $display("FAIL drop_latency: got %0d exp 1", n); end
        tests++; if (av !== 2'b01) begin fails++; $display("FAIL drop_ack: got %b exp 01", av); end
        tests++; if (rd !== 8'hA5) begin fails++; $display("FAIL drop_data: got %h exp a5", rd); end
        wait_ack_a(10, n, av, rd, iss, wc, wa, wd);
        if_a.req = 2'b00;
        cyc(1);
        tests++; if (av !== 2'b10) begin fails++; $display("FAIL drop_next_ack: got %b exp 10", av); end
        tests++; if (n !== 3) begin fails++; $display("FAIL drop_next_gap: got %0d exp 3", n); end
        tests++; if (wa !== 8'h50 || wd !== 8'h77) begin fails++; $display("FAIL drop_next_write: got %h/%h exp 50/77", wa, wd); end
    endtask

    task automatic test_wrap_skip();
        int n; logic [3:0] av; logic [7:0] rd;
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0010;
        rst_b = 1'b1; cyc(1); rst_b = 1'b0;
        if_b.we = 4'b1111;
        if_b.addr = {8'h63, 8'h62, 8'h61, 8'h60};
        if_b.wdata = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        // Serve core 2 so the pointer lands on 3.
        if_b.req = 4'b0100;
        wait_ack_b(10, n, av, rd);
        if_b.req = 4'b0000;
        cyc(1);
        tests++; if (av !== 4'b0100) begin fails++; $display("FAIL wrap_setup_ack: got %b exp 0100", av); end
        // ptr=3 with cores 1 and 3: 3 first, then wrap to 0 and skip to 1.
        if_b.req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            wait_ack_b(10, n, av, rd);
            tests++; if (av !== exp_seq[k]) begin fails++; $display("FAIL wrap_ack_%0d: got %b exp %b", k, av, exp_seq[k]); end
        end
        if_b.req = 4'b0000;
        cyc(1);
    endtask

    task automatic test_reset_mid_read();
        int n; logic [3:0] av; logic [7:0] rd;
        // Pointer is 2 here; core 3 wins, then reset lands mid-WAIT.
        if_b.we = 4'b0000;
        if_b.addr = {8'h41, 8'h00, 8'h40, 8'h00};
        if_b.req = 4'b1000;
        cyc(3);
        rst_b = 1'b1;
        if_b.req = 4'b1010;
        cyc(1);
        tests++; if (if_b.ack !== 4'b0000) begin fails++; $display("FAIL midrst_ack: got %b exp 0000", if_b.ack); end
        tests++; if (if_b.ram_wren !== 1'b0) begin fails++; $display("FAIL midrst_wren: got %b exp 0", if_b.ram_wren); end
        tests++; if (if_b.ram_addr !== 8'h00) begin fails++; $display("FAIL midrst_addr: got %h exp 00", if_b.ram_addr); end
        cyc(1);
        rst_b = 1'b0;
        wait_ack_b(20, n, av, rd);
        if_b.req = 4'b0000;
        cyc(1);
        tests++; if (av !== 4'b0010) begin fails++; $display("FAIL midrst_first_ack: got %b exp 0010", av); end
        tests++; if (n !== 5) begin fails++; $display("FAIL midrst_latency: got %0d exp 5", n); end
        tests++; if (rd !== 8'h5A) begin fails++; $display("FAIL midrst_data: got %h exp 5a", rd); end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ld_a = 1'b0; ld_b = 1'b0; ld_addr = '0; ld_data = '0;
        if_a.req = '0; if_a.we = '0; if_a.addr = '0; if_a.wdata = '0;
        if_b.req = '0; if_b.we = '0; if_b.addr = '0; if_b.wdata = '0;
        cyc(1);
        poke(1'b0, 8'h10, 8'hA5);
        poke(1'b1, 8'h40, 8'h5A);
        poke(1'b1, 8'h41, 8'hC3);
        test_reset();
        test_single_read();
        test_single_write();
        test_fairness();
        test_req_dropped();
        test_wrap_skip();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
